// File: rtl/sev_seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package sev_seg_pkg;

    localparam int unsigned BcdW      = 4;
    localparam int unsigned MaxDigits = 8;

    typedef enum logic [0:0] {StDead, StOn} scan_state_e;

    // Active-low anode mask with every implemented digit switched off.
    function automatic logic [MaxDigits-1:0] anode_all_off(input int unsigned num_digits);
        logic [MaxDigits-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MaxDigits; i++) begin
            if (i < num_digits) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/sev_seg_slot_timer.sv
// Slot/digit sequencer: counts cycles within a digit slot and walks the digit index.
module sev_seg_slot_timer #(
    parameter int unsigned NumDigits  = 4,
    parameter int unsigned RefreshDiv = 100000,
    parameter int unsigned DeadCycles = 500,
    localparam int unsigned SlotW     = $clog2(RefreshDiv),
    localparam int unsigned IdxW      = $clog2(NumDigits)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic [IdxW-1:0] digit_idx_o,
    output logic            in_dead_o,
    output logic            frame_end_o
);

    logic [SlotW-1:0] slot_cnt_q, slot_cnt_d;
    logic [IdxW-1:0]  digit_idx_q, digit_idx_d;
    logic             slot_end;

    // Next-state for the slot counter and digit index; index wraps explicitly.
    always_comb begin
        slot_end    = (slot_cnt_q == SlotW'(RefreshDiv - 1));
        slot_cnt_d  = slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            slot_cnt_d = '0;
            if (digit_idx_q == IdxW'(NumDigits - 1)) begin
                digit_idx_d = '0;
            end else begin
                digit_idx_d = digit_idx_q + 1'b1;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign digit_idx_o = digit_idx_q;
    assign in_dead_o   = (slot_cnt_q < SlotW'(DeadCycles));
    assign frame_end_o = slot_end && (digit_idx_q == IdxW'(NumDigits - 1));

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with double-buffered value,
// dead time, leading-zero suppression and whole-display blinking.
module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int unsigned NumDigits   = 4,
    parameter int unsigned RefreshDiv  = 100000,
    parameter int unsigned DeadCycles  = 500,
    parameter int unsigned BlinkFrames = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      load_i,
    input  logic [NumDigits*BcdW-1:0] value_i,
    input  logic                      blank_lz_i,
    input  logic                      blink_en_i,
    output logic [BcdW-1:0]           digit_bcd_o,
    output logic                      dec_blank_o,
    output logic [NumDigits-1:0]      anode_o,
    output logic                      load_ack_o,
    output logic                      frame_tick_o
);

    localparam int unsigned IdxW      = $clog2(NumDigits);
    localparam int unsigned BlinkCntW = (BlinkFrames > 1) ? $clog2(BlinkFrames) : 1;
    localparam int unsigned ValW      = NumDigits * BcdW;
    localparam logic [MaxDigits-1:0] AllOffWide  = anode_all_off(NumDigits);
    localparam logic [NumDigits-1:0] AnodeAllOff = AllOffWide[NumDigits-1:0];

    logic [IdxW-1:0] digit_idx;
    logic            in_dead;
    logic            frame_end;

    sev_seg_slot_timer #(
        .NumDigits  (NumDigits),
        .RefreshDiv (RefreshDiv),
        .DeadCycles (DeadCycles)
    ) u_slot_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .digit_idx_o (digit_idx),
        .in_dead_o   (in_dead),
        .frame_end_o (frame_end)
    );

    logic [ValW-1:0]      active_q, active_d;
    logic [ValW-1:0]      shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic [BlinkCntW-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_hidden_q, blink_hidden_d;
    logic [NumDigits-1:0] anode_q, anode_d;
    logic [BcdW-1:0]      digit_bcd_q, digit_bcd_d;
    logic                 dec_blank_q, dec_blank_d;
    logic                 load_ack_q, load_ack_d;
    logic                 frame_tick_q, frame_tick_d;

    logic [BcdW-1:0]      cur_bcd;
    logic                 cur_sup;
    logic [NumDigits-1:0] anode_on;
    scan_state_e          state;

    // Select the active digit; walk from the MSD down so the zero run covers digits above.
    always_comb begin
        logic lz_run;
        lz_run   = 1'b1;
        cur_bcd  = '0;
        cur_sup  = 1'b0;
        anode_on = AnodeAllOff;
        for (int i = NumDigits - 1; i >= 0; i--) begin
            lz_run = lz_run && (active_q[i*BcdW +: BcdW] == '0);
            if (digit_idx == IdxW'(i)) begin
                cur_bcd     = active_q[i*BcdW +: BcdW];
                cur_sup     = blank_lz_i && lz_run && (i != 0);
                anode_on[i] = 1'b0;
            end
        end
    end

    // Scan state and registered display outputs; state follows slot position only.
    always_comb begin
        state       = in_dead ? StDead : StOn;
        anode_d     = AnodeAllOff;
        dec_blank_d = 1'b1;
        digit_bcd_d = cur_bcd;
        unique case (state)
            StDead: ;
            StOn: begin
                if (!blink_hidden_q) begin
                    anode_d     = anode_on;
                    dec_blank_d = cur_sup;
                end
            end
            default: ;
        endcase
    end

    // Double-buffer commit, blink phase and frame pulses, all keyed to the frame boundary.
    always_comb begin
        active_d       = active_q;
        shadow_d       = shadow_q;
        pending_d      = pending_q;
        blink_cnt_d    = blink_cnt_q;
        blink_hidden_d = blink_hidden_q;
        load_ack_d     = frame_end && pending_q;
        frame_tick_d   = frame_end;
        if (frame_end && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        // A load on the boundary cycle lands after the commit and stays pending.
        if (load_i) begin
            shadow_d  = value_i;
            pending_d = 1'b1;
        end
        if (frame_end) begin
            if (blink_en_i) begin
                if (blink_cnt_q == BlinkCntW'(BlinkFrames - 1)) begin
                    blink_cnt_d    = '0;
                    blink_hidden_d = ~blink_hidden_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end else begin
                blink_cnt_d    = '0;
                blink_hidden_d = 1'b0;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q       <= '0;
            shadow_q       <= '0;
            pending_q      <= 1'b0;
            blink_cnt_q    <= '0;
            blink_hidden_q <= 1'b0;
            anode_q        <= AnodeAllOff;
            digit_bcd_q    <= '0;
            dec_blank_q    <= 1'b1;
            load_ack_q     <= 1'b0;
            frame_tick_q   <= 1'b0;
        end else begin
            active_q       <= active_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_hidden_q <= blink_hidden_d;
            anode_q        <= anode_d;
            digit_bcd_q    <= digit_bcd_d;
            dec_blank_q    <= dec_blank_d;
            load_ack_q     <= load_ack_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign anode_o      = anode_q;
    assign digit_bcd_o  = digit_bcd_q;
    assign dec_blank_o  = dec_blank_q;
    assign load_ack_o   = load_ack_q;
    assign frame_tick_o = frame_tick_q;

endmodule
